// File: rtl/message_encode_sequencer_pkg.sv
// Shared constants for the message encode sequencer: prime count, coefficient
// and write-data widths, the floor(q/2) table and the FSM state encoding.
package message_encode_sequencer_pkg;

   localparam int NUM_PRIMES = 6;
   localparam int COEF_W     = 30;
   localparam int DATA_W     = 2 * COEF_W;

   localparam logic [2:0] LAST_PRIME = 3'(NUM_PRIMES - 1);

   // floor(q_j / 2) for the six RNS primes
   localparam logic [COEF_W-1:0] QBY2_P0 = 30'd73728;
   localparam logic [COEF_W-1:0] QBY2_P1 = 30'd124928;
   localparam logic [COEF_W-1:0] QBY2_P2 = 30'd81920;
   localparam logic [COEF_W-1:0] QBY2_P3 = 30'd88064;
   localparam logic [COEF_W-1:0] QBY2_P4 = 30'd92160;
   localparam logic [COEF_W-1:0] QBY2_P5 = 30'd94208;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MSG = 2'd1,
      WRITE    = 2'd2,
      DONE     = 2'd3
   } seqState_t;

endpackage

// File: rtl/message_encode_sequencer_qby2_select.sv
// Combinational prime index -> floor(q/2) lookup. Indices past the last prime
// return 0 so an out-of-range counter can never produce a plausible value.
module message_encode_sequencer_qby2_select
   import message_encode_sequencer_pkg::*;
(
   input  logic [2:0]        primeIdx,
   output logic [COEF_W-1:0] qby2
);

   // table lookup
   always_comb begin
      qby2 = '0;
      case (primeIdx)
         3'd0:    qby2 = QBY2_P0;
         3'd1:    qby2 = QBY2_P1;
         3'd2:    qby2 = QBY2_P2;
         3'd3:    qby2 = QBY2_P3;
         3'd4:    qby2 = QBY2_P4;
         3'd5:    qby2 = QBY2_P5;
         default: qby2 = '0;
      endcase
   end

endmodule

// File: rtl/message_encode_sequencer.sv
// Message encode sequencer: accepts 2-bit plaintext messages and issues one
// coefficient-pair write per prime into the residue-polynomial memories.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | waiting for start; pair/prime counters held at 0
//   WAIT_MSG | msg_ready=1, waiting for the next message of the polynomial
//   WRITE    | six writes (primes 0..5) of the latched message at pairCnt
//   DONE     | one-cycle done pulse after the final pair, then IDLE
//
// Control outputs are registered from the next-state value, so they line up
// with the state register. Write prime/address/data decode straight from the
// counter and message-latch registers; nothing reaches an output from an
// input combinationally.
module message_encode_sequencer
   import message_encode_sequencer_pkg::*;
#(
   parameter int NUM_PAIRS = 2048,
   parameter int ADDR_W    = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              msg_valid,
   input  logic [1:0]        msg,
   output logic              msg_ready,
   output logic              wr_en,
   output logic [2:0]        wr_prime,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(NUM_PAIRS - 1);

   seqState_t         state;
   seqState_t         stateNext;
   logic [ADDR_W-1:0] pairCnt;
   logic [2:0]        primeCnt;
   logic [1:0]        msgLat;
   logic [COEF_W-1:0] qbyVal;
   logic              lastPrime;
   logic              lastPair;

   assign lastPrime = (primeCnt == LAST_PRIME);
   assign lastPair  = (pairCnt == LAST_PAIR);

   message_encode_sequencer_qby2_select uQby2 (
      .primeIdx (primeCnt),
      .qby2     (qbyVal)
   );

   assign wr_prime = primeCnt;
   assign wr_addr  = pairCnt;
   assign wr_data  = {msgLat[1] ? qbyVal : {COEF_W{1'b0}},
                      msgLat[0] ? qbyVal : {COEF_W{1'b0}}};

   // next-state decode; abort outranks every other transition
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (start && !abort) stateNext = WAIT_MSG;
         end
         WAIT_MSG: begin
            if (abort)          stateNext = IDLE;
            else if (msg_valid) stateNext = WRITE;
         end
         WRITE: begin
            if (abort)          stateNext = IDLE;
            else if (lastPrime) stateNext = lastPair ? DONE : WAIT_MSG;
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // state, counters, message latch and registered control outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pairCnt   <= '0;
         primeCnt  <= '0;
         msgLat    <= '0;
         msg_ready <= 1'b0;
         wr_en     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= stateNext;
         msg_ready <= (stateNext == WAIT_MSG);
         wr_en     <= (stateNext == WRITE);
         busy      <= (stateNext != IDLE);
         done      <= (stateNext == DONE);

         case (state)
            IDLE: begin
               pairCnt  <= '0;
               primeCnt <= '0;
            end
            WAIT_MSG: begin
               if (!abort && msg_valid) begin
                  msgLat   <= msg;
                  primeCnt <= '0;
               end
            end
            WRITE: begin
               // counters freeze on abort; IDLE clears them a cycle later
               if (!abort) begin
                  if (!lastPrime)     primeCnt <= primeCnt + 3'd1;
                  else if (!lastPair) pairCnt  <= pairCnt + ADDR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_message_encode_sequencer.sv
// Directed bench for message_encode_sequencer with a 4-pair polynomial.
module tb_message_encode_sequencer;

   localparam int NP = 4;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          abort;
   logic          msg_valid;
   logic [1:0]    msg;
   logic          msg_ready;
   logic          wr_en;
   logic [2:0]    wr_prime;
   logic [AW-1:0] wr_addr;
   logic [59:0]   wr_data;
   logic          busy;
   logic          done;

   int passCnt  = 0;
   int totalCnt = 0;

   logic [29:0] qTab [6] = '{30'd73728, 30'd124928, 30'd81920,
                             30'd88064, 30'd92160, 30'd94208};

   always #5 clk = ~clk;

   message_encode_sequencer #(.NUM_PAIRS(NP), .ADDR_W(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .msg_valid (msg_valid),
      .msg       (msg),
      .msg_ready (msg_ready),
      .wr_en     (wr_en),
      .wr_prime  (wr_prime),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy),
      .done      (done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      totalCnt++;
      assert (obs === exp) passCnt++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // checks nWrites consecutive write cycles; msg is switched to laterMsg
   // after the first write to show that the latched message is what is used
   task automatic checkWrites(input logic [1:0] m, input int addr, input int nWrites,
                              input logic [1:0] laterMsg);
      logic [59:0] expData;
      for (int j = 0; j < nWrites; j++) begin
         @(negedge clk);
         expData = {m[1] ? qTab[j] : 30'd0, m[0] ? qTab[j] : 30'd0};
         chk($sformatf("wr_en a%0d p%0d", addr, j), 64'(wr_en), 64'd1);
         chk($sformatf("wr_prime a%0d p%0d", addr, j), 64'(wr_prime), 64'(j));
         chk($sformatf("wr_addr a%0d p%0d", addr, j), 64'(wr_addr), 64'(addr));
         chk($sformatf("wr_data a%0d p%0d", addr, j), 64'(wr_data), 64'(expData));
         chk($sformatf("msg_ready in write a%0d p%0d", addr, j), 64'(msg_ready), 64'd0);
         if (j == 0) msg = laterMsg;
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; msg_valid = 1'b0; msg = 2'b00;

      // reset values
      repeat (2) @(negedge clk);
      chk("rst msg_ready", 64'(msg_ready), 64'd0);
      chk("rst wr_en", 64'(wr_en), 64'd0);
      chk("rst wr_prime", 64'(wr_prime), 64'd0);
      chk("rst wr_addr", 64'(wr_addr), 64'd0);
      chk("rst wr_data", 64'(wr_data), 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst done", 64'(done), 64'd0);

      // msg_valid without start is ignored
      rst = 1'b0; msg_valid = 1'b1; msg = 2'b11;
      repeat (3) begin
         @(negedge clk);
         chk("idle msg_ready", 64'(msg_ready), 64'd0);
         chk("idle wr_en", 64'(wr_en), 64'd0);
         chk("idle busy", 64'(busy), 64'd0);
      end

      // single pair, msg=10 -> high coefficient only
      start = 1'b1; msg = 2'b10;
      @(negedge clk);
      start = 1'b0;
      chk("start msg_ready", 64'(msg_ready), 64'd1);
      chk("start busy", 64'(busy), 64'd1);
      chk("start wr_en", 64'(wr_en), 64'd0);
      checkWrites(2'b10, 0, 6, 2'b10);
      @(negedge clk);
      chk("pair1 wait msg_ready", 64'(msg_ready), 64'd1);
      chk("pair1 wait wr_addr", 64'(wr_addr), 64'd1);
      msg_valid = 1'b0; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort wait busy", 64'(busy), 64'd0);
      chk("abort wait done", 64'(done), 64'd0);
      chk("abort wait msg_ready", 64'(msg_ready), 64'd0);
      @(negedge clk);

      // full polynomial, msg=11 held valid
      start = 1'b1; msg = 2'b11; msg_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("full msg_ready", 64'(msg_ready), 64'd1);
      for (int p = 0; p < NP; p++) begin
         checkWrites(2'b11, p, 6, 2'b11);
         if (p < NP - 1) begin
            @(negedge clk);
            chk($sformatf("full gap %0d msg_ready", p), 64'(msg_ready), 64'd1);
            chk($sformatf("full gap %0d wr_en", p), 64'(wr_en), 64'd0);
            chk($sformatf("full gap %0d wr_addr", p), 64'(wr_addr), 64'(p + 1));
         end
      end
      @(negedge clk);
      msg_valid = 1'b0;
      chk("done pulse", 64'(done), 64'd1);
      chk("done busy", 64'(busy), 64'd1);
      chk("done wr_en", 64'(wr_en), 64'd0);
      @(negedge clk);
      chk("after done done", 64'(done), 64'd0);
      chk("after done busy", 64'(busy), 64'd0);

      // backpressure: five idle cycles in WAIT_MSG
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp %0d msg_ready", i), 64'(msg_ready), 64'd1);
         chk($sformatf("bp %0d wr_en", i), 64'(wr_en), 64'd0);
         if (i < 4) @(negedge clk);
      end
      msg = 2'b01; msg_valid = 1'b1;
      checkWrites(2'b01, 0, 6, 2'b10);
      @(negedge clk);
      chk("bp next msg_ready", 64'(msg_ready), 64'd1);
      chk("bp next wr_addr", 64'(wr_addr), 64'd1);

      // abort at prime 2 of pair 1
      checkWrites(2'b10, 1, 3, 2'b10);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0; msg_valid = 1'b0;
      chk("abort wr_en", 64'(wr_en), 64'd0);
      chk("abort busy", 64'(busy), 64'd0);
      chk("abort done", 64'(done), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("post abort %0d wr_en", i), 64'(wr_en), 64'd0);
         chk($sformatf("post abort %0d done", i), 64'(done), 64'd0);
      end

      // restart begins at addr 0
      start = 1'b1; msg = 2'b11; msg_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("restart msg_ready", 64'(msg_ready), 64'd1);
      checkWrites(2'b11, 0, 3, 2'b11);

      // asynchronous reset in the middle of the prime-2 write
      rst = 1'b1;
      #1;
      chk("async rst wr_en", 64'(wr_en), 64'd0);
      chk("async rst busy", 64'(busy), 64'd0);
      chk("async rst wr_data", 64'(wr_data), 64'd0);
      chk("async rst msg_ready", 64'(msg_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0; start = 1'b1; msg = 2'b01; msg_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("post rst msg_ready", 64'(msg_ready), 64'd1);
      chk("post rst wr_addr", 64'(wr_addr), 64'd0);
      checkWrites(2'b01, 0, 6, 2'b01);
      @(negedge clk);
      msg_valid = 1'b0;
      chk("post rst gap msg_ready", 64'(msg_ready), 64'd1);
      chk("post rst gap wr_en", 64'(wr_en), 64'd0);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule

// File: doc/message_encode_sequencer.md
# message_encode_sequencer

Sequencer that turns a stream of 2-bit plaintext messages into RNS-encoded polynomial coefficients for all six primes. Each message carries a coefficient pair (bit 1 = high coefficient, bit 0 = low coefficient); each set bit encodes to ⌊q_j/2⌋ and each clear bit to 0. The block accepts messages over a valid/ready handshake, issues one write per prime into the residue-polynomial memories, and signals completion after a full polynomial. It sits between the host message FIFO and the coefficient BRAM write ports ahead of the encryption datapath.

## Interface
- NUM_PAIRS, 2048, coefficient pairs per polynomial (N/2); must be ≥ 2
- ADDR_W, 11, width of pair address; 2^ADDR_W ≥ NUM_PAIRS
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a polynomial; honoured only in IDLE
- abort  in  1  synchronous abandon, returns to IDLE without done
- msg_valid  in  1  message available
- msg  in  2  message pair {high, low}
- msg_ready  out  1  block can accept a message
- wr_en  out  1  coefficient write strobe
- wr_prime  out  3  prime index 0..5
- wr_addr  out  ADDR_W  pair index 0..NUM_PAIRS-1
- wr_data  out  60  {encoded high[59:30], encoded low[29:0]}
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last write of a polynomial

## Operation
- States: IDLE, WAIT_MSG, WRITE, DONE.
- IDLE: msg_ready=0, and the pair counter clears to 0. start=1 moves to WAIT_MSG.
- WAIT_MSG: msg_ready=1. On msg_valid&&msg_ready, msg is latched, the prime counter clears to 0, and the state moves to WRITE.
- WRITE: lasts 6 cycles. Each cycle wr_en=1, wr_prime is the prime counter, wr_addr is the pair counter, and wr_data = {msg_l[1] ? qby2(p) : 0, msg_l[0] ? qby2(p) : 0}.
  - The prime counter increments every cycle.
  - At prime 5, if pair = NUM_PAIRS-1 the state moves to DONE; otherwise pair increments and the state returns to WAIT_MSG.
- DONE: done=1 for one cycle, then IDLE.
- Constants qby2(0..5) = 73728, 124928, 81920, 88064, 92160, 94208, zero-extended to 30 bits.
- abort in any state other than IDLE forces IDLE on the next edge.
  - A write in flight on the abort cycle still completes that cycle; no further wr_en is issued and done is not asserted.
  - abort has priority over every other transition.
- start outside IDLE is ignored. msg_valid outside WAIT_MSG is ignored, with no consumption.
- start and abort in the same IDLE cycle: abort wins and the state stays IDLE.
- Pair and prime counters never wrap past NUM_PAIRS-1 or 5.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, latched message 0.
- All outputs are registered or decoded directly from state registers, with no combinational path from inputs to outputs.
- start sampled at edge t puts the block in WAIT_MSG from t+1, with msg_ready=1 from t+1.
- A handshake at edge t gives wr_en=1 on cycles t+1..t+6, with wr_prime 0..5 in order. msg_ready is 0 on those cycles.
- Throughput is 7 cycles per message with msg_valid held high. A polynomial takes 7·NUM_PAIRS cycles plus the start and done cycles.
- done rises on the cycle after the final write (prime 5, pair NUM_PAIRS-1). busy falls on the cycle after done.
- Reset asserted mid-WRITE clears wr_en immediately and asynchronously. After release, the block waits in IDLE for a new start.

## Structure
- Shared constants file holds:
  - the six qby2 values
  - NUM_PRIMES=6
  - state encodings (2-bit)
  - the 60-bit write-data width
- Sub-module qby2_select: combinational 3-bit prime index to 30-bit ⌊q/2⌋ lookup, returning 0 for indices 6 and 7. The top level instantiates it once, driven by the prime counter.
- The top level contains the FSM, the pair counter (ADDR_W bits), the prime counter (3 bits), the message latch and the output registers.

## Test plan
- Reset and idle check: with rst high then released, all outputs are 0. msg_valid=1 with no start gives msg_ready=0 and no wr_en.
- Single pair, msg=2'b10, NUM_PAIRS=2:
  - writes 0..5 at addr 0 carry wr_data = {qby2(j), 30'd0}
  - prime 1 gives high = 124928
- Full polynomial with msg=2'b11 for every pair (NUM_PAIRS=4):
  - 24 writes, addresses 0..3, each with primes 0..5 in order
  - one done pulse, exactly 7 cycles after the last handshake
- Backpressure: msg_valid low for 5 cycles in WAIT_MSG gives no writes, and msg_ready stays 1. Messages offered during WRITE are not consumed.
- abort during WRITE at prime 2: the prime-2 write is seen, then no further wr_en, and done never pulses. A following start begins again at addr 0.
- Asynchronous reset mid-WRITE clears wr_en within the same cycle. start plus msg=2'b01 afterwards gives low = qby2(j) and high = 0.
